// File: rtl/datapath.sv
// Eight-entry 4-bit register file with a 4-bit ALU and an edge-detected write strobe.
// Define DATAPATH_RES_REG_EN to register Res (one extra cycle of latency).
module datapath (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] EXTData,
   input  logic [2:0] AddrSrc1,
   input  logic [2:0] AddrSrc2,
   input  logic [2:0] AddrDest,
   input  logic       isExternal,
   input  logic       pushButn,
   input  logic [1:0] ALUSel,
   output logic [3:0] Res
);

   logic [7:0][3:0] r_regs;
   logic            r_btn_q;
   logic [3:0]      w_a;
   logic [3:0]      w_b;
   logic [3:0]      w_alu;
   logic [3:0]      w_wdata;
   logic            w_we;

   assign w_a = r_regs[AddrSrc1];
   assign w_b = r_regs[AddrSrc2];

   always_comb begin
      w_alu = 4'd0;
      case (ALUSel)
         2'b00:   w_alu = w_a + w_b;
         2'b01:   w_alu = w_a - w_b;
         2'b10:   w_alu = w_a & w_b;
         default: w_alu = w_a | w_b;
      endcase
   end

   assign w_wdata = isExternal ? EXTData : w_alu;
   // One write per press: a held button stays blocked until it is seen low.
   assign w_we    = pushButn & ~r_btn_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_regs  <= '0;
         r_btn_q <= 1'b0;
      end else begin
         r_btn_q <= pushButn;
         if (w_we) begin
            r_regs[AddrDest] <= w_wdata;
         end
      end
   end

`ifdef DATAPATH_RES_REG_EN
   logic [3:0] r_res;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_res <= 4'd0;
      end else begin
         r_res <= w_alu;
      end
   end

   assign Res = r_res;
`else
   assign Res = w_alu;
`endif

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: a behavioural register/ALU model checked every
// cycle, plus directed literal expectations that pin the model.
module tb_datapath;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] EXTData = 4'd0;
   logic [2:0] AddrSrc1 = 3'd0;
   logic [2:0] AddrSrc2 = 3'd0;
   logic [2:0] AddrDest = 3'd0;
   logic       isExternal = 1'b0;
   logic       pushButn = 1'b0;
   logic [1:0] ALUSel = 2'd0;
   logic [3:0] Res;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   int m_regs [8];
   bit m_btn;
   int m_res;

   datapath dut (
      .clk        (clk),
      .reset      (reset),
      .EXTData    (EXTData),
      .AddrSrc1   (AddrSrc1),
      .AddrSrc2   (AddrSrc2),
      .AddrDest   (AddrDest),
      .isExternal (isExternal),
      .pushButn   (pushButn),
      .ALUSel     (ALUSel),
      .Res        (Res)
   );

   always #5 clk = ~clk;

   function automatic int f_alu(int a, int b, int sel);
      case (sel)
         0:       return (a + b) % 16;
         1:       return (a - b + 16) % 16;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   function automatic int f_expected();
`ifdef DATAPATH_RES_REG_EN
      return m_res;
`else
      return f_alu(m_regs[AddrSrc1], m_regs[AddrSrc2], int'(ALUSel));
`endif
   endfunction

   // Reference model: a press is "button high now, low at the previous edge".
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] <= 0;
         m_btn <= 1'b0;
         m_res <= 0;
      end else begin
         m_res <= f_alu(m_regs[AddrSrc1], m_regs[AddrSrc2], int'(ALUSel));
         if (pushButn && !m_btn)
            m_regs[AddrDest] <= isExternal ? int'(EXTData)
                                           : f_alu(m_regs[AddrSrc1], m_regs[AddrSrc2], int'(ALUSel));
         m_btn <= pushButn;
      end
   end

   task automatic chk(string name, logic [3:0] act, int exp);
      n_checks++;
      if (act !== exp[3:0]) begin
         n_errors++;
         $display("FAIL %s: Res=%0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) chk("cycle", Res, f_expected());
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(string name, int exp);
`ifdef DATAPATH_RES_REG_EN
      tick();
`endif
      #1;
      chk(name, Res, exp);
   endtask

   task automatic press();
      pushButn = 1'b1;
      tick();
      pushButn = 1'b0;
      tick();
   endtask

   task automatic wr_ext(logic [2:0] addr, logic [3:0] data);
      isExternal = 1'b1;
      EXTData    = data;
      AddrDest   = addr;
      press();
   endtask

   initial begin
      #1 reset = 1'b1;
      check_en = 1'b1;
      ALUSel = 2'b00; AddrSrc1 = 3'd1; AddrSrc2 = 3'd2;
      lit("reset_add", 0);
      isExternal = 1'b1; EXTData = 4'd9; AddrDest = 3'd1;
      press();
      for (int s = 0; s < 4; s++) begin
         ALUSel = s[1:0];
         lit("reset_alusel", 0);
      end
      ALUSel = 2'b11; AddrSrc2 = 3'd0;
      for (int r = 0; r < 8; r++) begin
         AddrSrc1 = r[2:0];
         lit("reset_reg", 0);
      end
      reset = 1'b0;
      tick();

      wr_ext(3'd1, 4'd5);
      wr_ext(3'd2, 4'd3);
      AddrSrc1 = 3'd1; AddrSrc2 = 3'd2;
      ALUSel = 2'b00; lit("add_5_3", 8);
      ALUSel = 2'b10; lit("and_5_3", 1);
      ALUSel = 2'b11; lit("or_5_3", 7);

      AddrSrc1 = 3'd2; AddrSrc2 = 3'd1; ALUSel = 2'b01;
      lit("sub_wrap", 14);
      wr_ext(3'd3, 4'd15);
      wr_ext(3'd4, 4'd1);
      AddrSrc1 = 3'd3; AddrSrc2 = 3'd4; ALUSel = 2'b00;
      lit("add_carry_drop", 0);

      isExternal = 1'b0; ALUSel = 2'b00; AddrSrc1 = 3'd1; AddrSrc2 = 3'd2;
      AddrDest = 3'd3;
      press();
      AddrSrc1 = 3'd3; AddrSrc2 = 3'd0; ALUSel = 2'b11;
      lit("wb_r3", 8);
      ALUSel = 2'b00; AddrSrc1 = 3'd1; AddrSrc2 = 3'd2; AddrDest = 3'd1;
      press();
      AddrSrc1 = 3'd1; AddrSrc2 = 3'd0; ALUSel = 2'b11;
      lit("wb_r1_self", 8);

      wr_ext(3'd1, 4'd1);
      isExternal = 1'b0; ALUSel = 2'b00;
      AddrSrc1 = 3'd1; AddrSrc2 = 3'd1; AddrDest = 3'd1;
      pushButn = 1'b1;
      repeat (5) tick();
      pushButn = 1'b0;
      tick();
      ALUSel = 2'b11;
      lit("held_single", 2);
      ALUSel = 2'b00;
      press();
      ALUSel = 2'b11;
      lit("repress", 4);

      AddrSrc1 = 3'd1; AddrSrc2 = 3'd2; ALUSel = 2'b11;
      lit("pre_reset", 7);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 chk("async_reset", Res, 0);
      AddrSrc2 = 3'd0;
      for (int r = 1; r < 4; r++) begin
         AddrSrc1 = r[2:0];
         lit("reset_mid_reg", 0);
      end
      isExternal = 1'b1; EXTData = 4'd9; AddrDest = 3'd5;
      pushButn = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      EXTData = 4'd6;
      repeat (3) tick();
      pushButn = 1'b0;
      tick();
      AddrSrc1 = 3'd5; AddrSrc2 = 3'd0; ALUSel = 2'b11;
      lit("reset_release_press", 9);
      AddrSrc1 = 3'd1;
      lit("post_reset_r1", 0);

      tick();
      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
